// File: rtl/pb_ser_pkg.sv
// Shared definitions for the protobuf scalar-field serializer: type codes, sizes, FSM states.
package pb_ser_pkg;

    localparam int unsigned MAX_VARINT_BYTES = 10;
    localparam int unsigned LEN_W            = 4;
    localparam int unsigned FT_W             = 5;

    localparam logic [FT_W-1:0] FT_DOUBLE   = 5'd1;
    localparam logic [FT_W-1:0] FT_FLOAT    = 5'd2;
    localparam logic [FT_W-1:0] FT_INT64    = 5'd3;
    localparam logic [FT_W-1:0] FT_UINT64   = 5'd4;
    localparam logic [FT_W-1:0] FT_INT32    = 5'd5;
    localparam logic [FT_W-1:0] FT_FIXED64  = 5'd6;
    localparam logic [FT_W-1:0] FT_FIXED32  = 5'd7;
    localparam logic [FT_W-1:0] FT_BOOL     = 5'd8;
    localparam logic [FT_W-1:0] FT_UINT32   = 5'd13;
    localparam logic [FT_W-1:0] FT_ENUM     = 5'd14;
    localparam logic [FT_W-1:0] FT_SFIXED32 = 5'd15;
    localparam logic [FT_W-1:0] FT_SFIXED64 = 5'd16;
    localparam logic [FT_W-1:0] FT_SINT32   = 5'd17;
    localparam logic [FT_W-1:0] FT_SINT64   = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FIN
    } state_e;

    // Encoded field: bytes[0] is the least significant byte of the wire encoding.
    typedef struct packed {
        logic                                   unsupported;
        logic [LEN_W-1:0]                       len;
        logic [MAX_VARINT_BYTES-1:0][7:0]       bytes;
    } enc_t;

endpackage

// File: rtl/pb_field_encoder.sv
// Combinational encoder: (value, field_type) -> wire bytes, length and unsupported flag.
module pb_field_encoder
    import pb_ser_pkg::*;
(
    input  logic [63:0]     value,
    input  logic [FT_W-1:0] field_type,
    output enc_t            enc_c
);

    logic [31:0]      zz32;
    logic [63:0]      zz64;
    logic [63:0]      vval;
    logic [LEN_W-1:0] vlen;
    logic             is_var;
    logic             is_f64;
    logic             is_f32;

    zigzag #(.W(32)) u_zz32 (.in_val(value[31:0]), .out_val(zz32));
    zigzag #(.W(64)) u_zz64 (.in_val(value),       .out_val(zz64));

    always_comb begin
        enc_c  = '0;
        vval   = value;
        is_var = 1'b0;
        is_f64 = 1'b0;
        is_f32 = 1'b0;
        case (field_type)
            FT_INT64, FT_UINT64, FT_BOOL, FT_ENUM: is_var = 1'b1;
            FT_INT32, FT_UINT32: begin
                is_var = 1'b1;
                vval   = {32'd0, value[31:0]};
            end
            FT_SINT32: begin
                is_var = 1'b1;
                vval   = {32'd0, zz32};
            end
            FT_SINT64: begin
                is_var = 1'b1;
                vval   = zz64;
            end
            FT_DOUBLE, FT_FIXED64, FT_SFIXED64: is_f64 = 1'b1;
            FT_FLOAT, FT_FIXED32, FT_SFIXED32:  is_f32 = 1'b1;
            default: enc_c.unsupported = 1'b1;
        endcase

        // Varint length is one past the highest non-zero 7-bit group; zero still takes one byte.
        vlen = 4'd1;
        for (int k = 1; k < int'(MAX_VARINT_BYTES); k++) begin
            if (7'(vval >> (7 * k)) != 7'd0) vlen = 4'(k + 1);
        end

        if (is_var) begin
            enc_c.len = vlen;
            for (int k = 0; k < int'(MAX_VARINT_BYTES); k++) begin
                enc_c.bytes[k] = {(4'(k) < (vlen - 4'd1)), 7'(vval >> (7 * k))};
            end
        end else if (is_f64) begin
            enc_c.len = 4'd8;
            for (int k = 0; k < 8; k++) enc_c.bytes[k] = value[8*k +: 8];
        end else if (is_f32) begin
            enc_c.len = 4'd4;
            for (int k = 0; k < 4; k++) enc_c.bytes[k] = value[8*k +: 8];
        end
    end

endmodule

// File: rtl/zigzag.sv
// Zigzag mapping of a signed value: small magnitudes map to small unsigned codes.
module zigzag #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] in_val,
    output logic [W-1:0] out_val
);

    assign out_val = (in_val << 1) ^ {W{in_val[W-1]}};

endmodule

// File: rtl/pb_field_ser_engine.sv
// Serializes one protobuf scalar field backward from dst_addr over LANES DRAM byte lanes per beat.
module pb_field_ser_engine
    import pb_ser_pkg::*;
#(
    parameter int unsigned LANES    = 8,
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned DRAM_LAT = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         dst_addr,
    input  logic [63:0]               value,
    input  logic [FT_W-1:0]           field_type,
    output logic [LANES-1:0]          dram_en,
    output logic [LANES*ADDR_W-1:0]   dram_addr,
    output logic [LANES*8-1:0]        dram_data,
    output logic                      dram_rdwr,
    output logic                      done,
    output logic                      err,
    output logic [LEN_W-1:0]          bytes_written
);

    localparam int unsigned LAT_W = (DRAM_LAT > 1) ? $clog2(DRAM_LAT) : 1;

    state_e                            state_q, state_d;
    logic [MAX_VARINT_BYTES-1:0][7:0]  buf_q, buf_d;
    logic [LEN_W-1:0]                  len_q, len_d;
    logic [ADDR_W-1:0]                 dst_q, dst_d;
    logic [LEN_W-1:0]                  bw_q, bw_d;
    logic [LAT_W-1:0]                  lat_q, lat_d;
    logic [LANES-1:0]                  en_q, en_d;
    logic [LANES-1:0][ADDR_W-1:0]      addr_q, addr_d;
    logic [LANES-1:0][7:0]             data_q, data_d;
    logic                              done_q, done_d;
    logic                              err_q, err_d;

    enc_t                              enc_c;
    logic [MAX_VARINT_BYTES-1:0][7:0]  src_bytes;
    logic [LEN_W-1:0]                  src_len;
    logic [ADDR_W-1:0]                 src_dst;
    logic [LEN_W-1:0]                  src_bw;
    logic [LEN_W-1:0]                  rem;
    logic [LEN_W-1:0]                  beat_cnt;
    logic [LANES-1:0]                  lane_en;
    logic [LANES-1:0][LEN_W-1:0]       lane_idx;
    logic [LANES-1:0][ADDR_W-1:0]      lane_addr;
    logic [LANES-1:0][7:0]             lane_data;
    logic                              load_beat;

    pb_field_encoder u_enc (
        .value      (value),
        .field_type (field_type),
        .enc_c      (enc_c)
    );

    // First beat is built straight from the encoder at accept; later beats from the latched copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            src_bytes = enc_c.bytes;
            src_len   = enc_c.len;
            src_dst   = dst_addr;
            src_bw    = '0;
        end else begin
            src_bytes = buf_q;
            src_len   = len_q;
            src_dst   = dst_q;
            src_bw    = bw_q;
        end
        rem      = src_len - src_bw;
        beat_cnt = (rem > 4'(LANES)) ? 4'(LANES) : rem;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_en[i]   = 4'(i) < rem;
            lane_idx[i]  = rem - 4'd1 - 4'(i);
            lane_addr[i] = src_dst - ADDR_W'(src_bw) - ADDR_W'(i);
            lane_data[i] = lane_en[i] ? src_bytes[lane_idx[i]] : 8'd0;
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        len_d     = len_q;
        dst_d     = dst_q;
        bw_d      = bw_q;
        lat_d     = lat_q;
        en_d      = '0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = err_q;
        load_beat = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    buf_d = enc_c.bytes;
                    len_d = enc_c.len;
                    dst_d = dst_addr;
                    bw_d  = '0;
                    err_d = enc_c.unsupported;
                    if (enc_c.unsupported) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_ISSUE;
                        load_beat = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                bw_d    = bw_q + beat_cnt;
                lat_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LAT_W'(DRAM_LAT - 1)) begin
                    if (bw_q < len_q) begin
                        state_d   = ST_ISSUE;
                        load_beat = 1'b1;
                    end else begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Disabled lanes keep their previous address/data.
        if (load_beat) begin
            en_d = lane_en;
            for (int i = 0; i < int'(LANES); i++) begin
                if (lane_en[i]) begin
                    addr_d[i] = lane_addr[i];
                    data_d[i] = lane_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            len_q   <= '0;
            dst_q   <= '0;
            bw_q    <= '0;
            lat_q   <= '0;
            en_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            dst_q   <= dst_d;
            bw_q    <= bw_d;
            lat_q   <= lat_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign dram_en       = en_q;
    assign dram_addr     = addr_q;
    assign dram_data     = data_q;
    assign dram_rdwr     = 1'b0;
    assign done          = done_q;
    assign err           = err_q;
    assign bytes_written = bw_q;

endmodule

// File: tb/tb_pb_field_ser_engine.sv
// Directed bench for pb_field_ser_engine: an 8-lane/20-cycle instance and a 3-lane/2-cycle instance.
module tb_pb_field_ser_engine;

    localparam int unsigned AW = 64;
    localparam int unsigned LA = 8;
    localparam int unsigned TA = 20;
    localparam int unsigned LB = 3;
    localparam int unsigned TB = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             a_valid = 1'b0, a_ready, a_rdwr, a_done, a_err;
    logic [AW-1:0]    a_dst = '0;
    logic [63:0]      a_value = '0;
    logic [4:0]       a_ft = '0;
    logic [LA-1:0]    a_en;
    logic [LA*AW-1:0] a_addr;
    logic [LA*8-1:0]  a_data;
    logic [3:0]       a_bw;

    logic             b_valid = 1'b0, b_ready, b_rdwr, b_done, b_err;
    logic [AW-1:0]    b_dst = '0;
    logic [63:0]      b_value = '0;
    logic [4:0]       b_ft = '0;
    logic [LB-1:0]    b_en;
    logic [LB*AW-1:0] b_addr;
    logic [LB*8-1:0]  b_data;
    logic [3:0]       b_bw;

    int n_checks = 0;
    int n_errors = 0;

    pb_field_ser_engine #(.LANES(LA), .ADDR_W(AW), .DRAM_LAT(TA)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
        .dst_addr(a_dst), .value(a_value), .field_type(a_ft),
        .dram_en(a_en), .dram_addr(a_addr), .dram_data(a_data), .dram_rdwr(a_rdwr),
        .done(a_done), .err(a_err), .bytes_written(a_bw)
    );

    pb_field_ser_engine #(.LANES(LB), .ADDR_W(AW), .DRAM_LAT(TB)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
        .dst_addr(b_dst), .value(b_value), .field_type(b_ft),
        .dram_en(b_en), .dram_addr(b_addr), .dram_data(b_data), .dram_rdwr(b_rdwr),
        .done(b_done), .err(b_err), .bytes_written(b_bw)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sample(input int inst, output logic [9:0] en, output logic [9:0][63:0] addr,
                          output logic [9:0][7:0] data, output logic dn, output logic er,
                          output logic [3:0] bw, output logic rdy);
        en = '0; addr = '0; data = '0;
        if (inst == 0) begin
            en = 10'(a_en);
            for (int i = 0; i < int'(LA); i++) begin
                addr[i] = a_addr[i*AW +: AW];
                data[i] = a_data[i*8 +: 8];
            end
            dn = a_done; er = a_err; bw = a_bw; rdy = a_ready;
        end else begin
            en = 10'(b_en);
            for (int i = 0; i < int'(LB); i++) begin
                addr[i] = b_addr[i*AW +: AW];
                data[i] = b_data[i*8 +: 8];
            end
            dn = b_done; er = b_err; bw = b_bw; rdy = b_ready;
        end
    endtask

    // exp_b[8k +: 8] holds encoded byte b[k]; emission order is b[len-1] down to b[0].
    task automatic run_req(input int inst, input string name, input logic [63:0] dst,
                           input logic [63:0] val, input logic [4:0] ft, input int len,
                           input logic [79:0] exp_b, input logic exp_err);
        logic [9:0]       en;
        logic [9:0][63:0] addr;
        logic [9:0][7:0]  data;
        logic             dn, er, rdy;
        logic [3:0]       bw;
        int lanes, lat, nbytes, nbeats, done_cyc, exp_cnt, exp_done;
        lanes = (inst == 0) ? int'(LA) : int'(LB);
        lat   = (inst == 0) ? int'(TA) : int'(TB);

        @(negedge clk);
        sample(inst, en, addr, data, dn, er, bw, rdy);
        check_eq({name, ".ready_before"}, 64'(rdy), 64'd1);
        if (inst == 0) begin a_valid = 1'b1; a_dst = dst; a_value = val; a_ft = ft; end
        else           begin b_valid = 1'b1; b_dst = dst; b_value = val; b_ft = ft; end
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the engine must ignore them.
        if (inst == 0) begin a_valid = 1'b0; a_dst = ~dst; a_value = ~val; a_ft = 5'd11; end
        else           begin b_valid = 1'b0; b_dst = ~dst; b_value = ~val; b_ft = 5'd11; end

        nbytes = 0; nbeats = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            sample(inst, en, addr, data, dn, er, bw, rdy);
            if (en != 10'd0) begin
                exp_cnt = len - nbeats * lanes;
                if (exp_cnt > lanes) exp_cnt = lanes;
                if (exp_cnt < 0) exp_cnt = 0;
                check_eq({name, ".beat_cycle"}, 64'(cyc), 64'(1 + nbeats * (lat + 1)));
                check_eq({name, ".beat_en"}, 64'(en), 64'((1 << exp_cnt) - 1));
                for (int i = 0; i < lanes; i++) begin
                    if (en[i]) begin
                        if (nbytes < len) begin
                            check_eq({name, ".data"}, 64'(data[i]), 64'(exp_b[8*(len-1-nbytes) +: 8]));
                            check_eq({name, ".addr"}, addr[i], dst - 64'(nbytes));
                        end
                        nbytes++;
                    end
                end
                nbeats++;
            end
            if (dn) begin
                done_cyc = cyc;
                check_eq({name, ".bytes_written"}, 64'(bw), 64'(len));
                check_eq({name, ".err"}, 64'(er), 64'(exp_err));
            end
        end
        exp_done = (len == 0) ? 1 : ((len + lanes - 1) / lanes) * (lat + 1) + 1;
        check_eq({name, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check_eq({name, ".byte_count"}, 64'(nbytes), 64'(len));

        @(negedge clk);
        sample(inst, en, addr, data, dn, er, bw, rdy);
        check_eq({name, ".ready_after"}, 64'(rdy), 64'd1);
        check_eq({name, ".bw_hold"}, 64'(bw), 64'(len));
        check_eq({name, ".err_hold"}, 64'(er), 64'(exp_err));
        check_eq({name, ".done_pulse"}, 64'(dn), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check_eq("rst.ready", 64'(a_ready), 64'd1);
        check_eq("rst.done", 64'(a_done), 64'd0);
        check_eq("rst.err", 64'(a_err), 64'd0);
        check_eq("rst.bw", 64'(a_bw), 64'd0);
        check_eq("rst.en", 64'(a_en), 64'd0);
        check_eq("rst.addr0", a_addr[AW-1:0], 64'd0);
        check_eq("rst.rdwr", 64'(a_rdwr), 64'd0);
        check_eq("rst.b_ready", 64'(b_ready), 64'd1);

        run_req(0, "u64_300",      64'h1000, 64'd300, 5'd4, 2, 80'h02AC, 1'b0);
        run_req(0, "s32_m1",       64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 1, 80'h01, 1'b0);
        run_req(0, "i64_zero",     64'h3000, 64'd0, 5'd3, 1, 80'h00, 1'b0);
        run_req(0, "i64_m1",       64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 10,
                80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF, 1'b0);
        run_req(0, "fx32",         64'h20, 64'h0000_0000_1234_5678, 5'd7, 4, 80'h1234_5678, 1'b0);
        run_req(0, "unsupported",  64'h5000, 64'd7, 5'd11, 0, 80'h0, 1'b1);
        run_req(0, "u32_mask",     64'h6000, 64'hFFFF_FFFF_0000_0080, 5'd13, 2, 80'h0180, 1'b0);
        run_req(0, "s64_m2",       64'h7000, 64'hFFFF_FFFF_FFFF_FFFE, 5'd18, 1, 80'h03, 1'b0);
        run_req(0, "wrap",         64'h0, 64'd300, 5'd4, 2, 80'h02AC, 1'b0);
        run_req(1, "b_fx64",       64'h500, 64'h0102_0304_0506_0708, 5'd6, 8,
                80'h0102_0304_0506_0708, 1'b0);
        run_req(1, "b_sfx32",      64'h10, 64'h0000_0000_DEAD_BEEF, 5'd15, 4, 80'hDEAD_BEEF, 1'b0);

        // Reset in the second WAIT cycle aborts the transfer.
        @(negedge clk);
        a_valid = 1'b1; a_dst = 64'h8000; a_value = 64'hFFFF_FFFF_FFFF_FFFF; a_ft = 5'd3;
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        check_eq("rstmid.first_beat", 64'(a_en), 64'hFF);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rstmid.en", 64'(a_en), 64'd0);
        check_eq("rstmid.done", 64'(a_done), 64'd0);
        check_eq("rstmid.ready", 64'(a_ready), 64'd1);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (a_done || a_en != '0) seen++;
            end
            check_eq("rstmid.quiet", 64'(seen), 64'd0);
        end

        run_req(0, "after_rst", 64'h9000, 64'd300, 5'd4, 2, 80'h02AC, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
